// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry synchronous FIFO: operation state encodings
// and the default pointer width. Used by the controller, flag decoder and register file.
package fifo_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 3;

   typedef enum logic [2:0] {
      StInit    = 3'b000,
      StWrite   = 3'b001,
      StRead    = 3'b010,
      StWrError = 3'b101,
      StRdError = 3'b110,
      StNoOp    = 3'b111
   } state_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a requester and the FIFO sequencing controller.
//   wr_en, rd_en   : per-cycle write/read requests (requester -> controller)
//   state          : registered operation state
//   data_count     : registered occupancy, 0..2**ADDR_W
//   we, wr_addr    : write strobe and address into the register file
//   re, rd_addr    : read strobe and address into the register file
// master = requester side, slave = controller side.
interface fifo_ctrl_if #(
   parameter int unsigned ADDR_W = fifo_pkg::ADDR_W_DEFAULT
);
   import fifo_pkg::*;

   logic              wr_en;
   logic              rd_en;
   state_e            state;
   logic [ADDR_W:0]   data_count;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic              re;
   logic [ADDR_W-1:0] rd_addr;

   modport master (
      output wr_en, rd_en,
      input  state, data_count, we, wr_addr, re, rd_addr
   );

   modport slave (
      input  wr_en, rd_en,
      output state, data_count, we, wr_addr, re, rd_addr
   );

endinterface

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state logic of the FIFO controller.
//   wr_en, rd_en       : requests for this cycle
//   count, head, tail  : current occupancy and pointers
//   state_d, count_d,
//   head_d, tail_d     : values to load at the next rising edge
//   we, re             : register-file strobes, asserted only for accepted requests
module fifo_ctrl_ns
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W:0]   count,
   input  logic [ADDR_W-1:0] head,
   input  logic [ADDR_W-1:0] tail,
   output state_e            state_d,
   output logic [ADDR_W:0]   count_d,
   output logic [ADDR_W-1:0] head_d,
   output logic [ADDR_W-1:0] tail_d,
   output logic              we,
   output logic              re
);

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   logic is_full;
   logic is_empty;

   assign is_full  = (count == FULL);
   assign is_empty = (count == '0);

   // Pointers carry no wrap bit; full/empty come from count alone, so the
   // natural ADDR_W-bit overflow gives the modulo-depth wrap.
   always_comb begin
      state_d = StNoOp;
      count_d = count;
      head_d  = head;
      tail_d  = tail;
      we      = 1'b0;
      re      = 1'b0;
      case ({wr_en, rd_en})
         2'b10: begin
            if (is_full) begin
               state_d = StWrError;
            end else begin
               state_d = StWrite;
               we      = 1'b1;
               count_d = count + 1'b1;
               tail_d  = tail + 1'b1;
            end
         end
         2'b01: begin
            if (is_empty) begin
               state_d = StRdError;
            end else begin
               state_d = StRead;
               re      = 1'b1;
               count_d = count - 1'b1;
               head_d  = head + 1'b1;
            end
         end
         // Idle and simultaneous requests are both a refused no-op.
         default: ;
      endcase
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the 8-entry synchronous FIFO. Holds the operation
// state, occupancy counter and head/tail pointers; decisions come from fifo_ctrl_ns.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of fifo_ctrl_if (requests in, state/count/strobes/addresses out)
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input logic       clk,
   input logic       reset_n,
   fifo_ctrl_if.slave bus
);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] head_q, head_d;
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic              we;
   logic              re;

   fifo_ctrl_ns #(
      .ADDR_W(ADDR_W)
   ) u_ns (
      .wr_en  (bus.wr_en),
      .rd_en  (bus.rd_en),
      .count  (count_q),
      .head   (head_q),
      .tail   (tail_q),
      .state_d(state_d),
      .count_d(count_d),
      .head_d (head_d),
      .tail_d (tail_d),
      .we     (we),
      .re     (re)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StInit;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.data_count = count_q;
   assign bus.we         = we;
   assign bus.re         = re;
   assign bus.wr_addr    = tail_q;
   assign bus.rd_addr    = head_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

   localparam int unsigned AW    = 3;
   localparam int          DEPTH = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   fifo_ctrl_if #(.ADDR_W(AW)) bus ();

   fifo_ctrl #(
      .ADDR_W(AW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Reference model: queue of occupied slot addresses, oldest first.
   int m_q[$];
   int m_head  = 0;
   int m_tail  = 0;
   int m_state = 0;
   int cmp_n;

   int pre_we, pre_re, pre_wa, pre_ra;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_head  = 0;
         m_tail  = 0;
         m_state = 0;
      end else if (bus.wr_en && !bus.rd_en) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back(m_tail);
            m_tail  = (m_tail + 1) % DEPTH;
            m_state = 1;
         end else begin
            m_state = 5;
         end
      end else if (bus.rd_en && !bus.wr_en) begin
         if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_head  = (m_head + 1) % DEPTH;
            m_state = 2;
         end else begin
            m_state = 6;
         end
      end else begin
         m_state = 7;
      end
   end

   // Compare every cycle on the falling edge; inputs are stable then.
   always @(negedge clk) begin
      if (check_en) begin
         cmp_n = m_q.size();
         chk("state", int'(bus.state), m_state);
         chk("data_count", int'(bus.data_count), cmp_n);
         chk("wr_addr", int'(bus.wr_addr), m_tail);
         chk("rd_addr", int'(bus.rd_addr), (cmp_n > 0) ? m_q[0] : m_head);
         chk("we", int'(bus.we), int'(bus.wr_en && !bus.rd_en && cmp_n < DEPTH));
         chk("re", int'(bus.re), int'(bus.rd_en && !bus.wr_en && cmp_n > 0));
      end
   end

   // One request cycle: drive after the falling edge, capture the combinational
   // outputs before the rising edge, return just after the rising edge.
   task automatic do_op(input bit w, input bit r);
      @(negedge clk);
      #1;
      bus.wr_en = w;
      bus.rd_en = r;
      #1;
      pre_we = int'(bus.we);
      pre_re = int'(bus.re);
      pre_wa = int'(bus.wr_addr);
      pre_ra = int'(bus.rd_addr);
      @(posedge clk);
      #2;
   endtask

   task automatic reset_mid();
      @(negedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_count", int'(bus.data_count), 0);
      chk("rst_wr_addr", int'(bus.wr_addr), 0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;

      // 1. reset mid-cycle, then an idle first edge
      #3;
      reset_n = 1'b0;
      #1;
      chk("init_state", int'(bus.state), 0);
      chk("init_count", int'(bus.data_count), 0);
      @(negedge clk);
      #1;
      reset_n  = 1'b1;
      check_en = 1'b1;
      @(posedge clk);
      #2;
      chk("idle_state", int'(bus.state), 7);

      // 2. fill and overflow
      for (int i = 0; i < 8; i++) begin
         do_op(1'b1, 1'b0);
         chk("fill_wr_addr", pre_wa, i);
         chk("fill_count", int'(bus.data_count), i + 1);
         chk("fill_state", int'(bus.state), 1);
      end
      do_op(1'b1, 1'b0);
      chk("ovf_state", int'(bus.state), 5);
      chk("ovf_we", pre_we, 0);
      chk("ovf_count", int'(bus.data_count), 8);
      chk("ovf_tail", int'(bus.wr_addr), 0);

      // 3. drain, then underflow
      for (int i = 0; i < 8; i++) begin
         do_op(1'b0, 1'b1);
         chk("drain_rd_addr", pre_ra, i);
      end
      do_op(1'b0, 1'b1);
      chk("udf_state", int'(bus.state), 6);
      chk("udf_re", pre_re, 0);
      chk("udf_count", int'(bus.data_count), 0);
      chk("udf_head", int'(bus.rd_addr), 0);

      // 4. simultaneous requests at count 3
      for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0);
      do_op(1'b1, 1'b1);
      chk("both_state", int'(bus.state), 7);
      chk("both_count", int'(bus.data_count), 3);
      chk("both_tail", int'(bus.wr_addr), 3);
      chk("both_head", int'(bus.rd_addr), 0);
      chk("both_we", pre_we, 0);
      chk("both_re", pre_re, 0);
      for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1);

      // 5. wrap-around from fresh pointers
      reset_mid();
      for (int i = 0; i < 6; i++) do_op(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) do_op(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         do_op(1'b1, 1'b0);
         chk("wrap_wr_addr", pre_wa, (6 + i) % 8);
      end
      chk("wrap_tail", int'(bus.wr_addr), 3);
      chk("wrap_head", int'(bus.rd_addr), 6);
      chk("wrap_count", int'(bus.data_count), 5);

      // 6. reset mid-operation at count 5
      reset_mid();
      do_op(1'b1, 1'b0);
      chk("post_rst_wr_addr", pre_wa, 0);
      chk("post_rst_count", int'(bus.data_count), 1);

      // Randomized traffic, with an occasional asynchronous reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            reset_mid();
         end else begin
            do_op(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45));
         end
      end
      do_op(1'b0, 1'b0);
      @(negedge clk);
      #1;
      check_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
